alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single 8-bit ALU datapath between two requesters (r0, r1) with round-robin arbitration.
- Each requester issues {fun_sel, a, b} with a valid/ready handshake.
- The block drives the ALU, captures the ALU result and flags into a per-requester response slot, and returns them with a valid/ready handshake.
- Sits between the control units and the ALU; nothing else drives the ALU inputs.

Parameters:
- DATA_W, 8, operand/result width.
- FUNSEL_W, 4, ALU function-select width.
- FLAG_W, 4, ALU flag width (bit3 Z, bit2 C, bit1 N, bit0 O).
- INIT_PRIO, 0, requester that wins the first tie after reset (0 or 1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rX_valid  in  1  request valid, X in {0,1}.
- rX_ready  out  1  request accepted this cycle (combinational).
- rX_fun_sel  in  FUNSEL_W  ALU function for request.
- rX_a, rX_b  in  DATA_W  operands.
- rX_lock  in  1  hold ALU ownership after this op (used only with ALU_ARB_LOCK_EN).
- rX_rsp_valid  out  1  response slot full.
- rX_rsp_ready  in  1  requester consumes response.
- rX_rsp_out  out  DATA_W  captured ALU result.
- rX_rsp_flags  out  FLAG_W  captured ALU flags.
- alu_fun_sel  out  FUNSEL_W  to ALU function select.
- alu_a, alu_b  out  DATA_W  to ALU operands.
- alu_out  in  DATA_W  ALU result (combinational).
- alu_flags  in  FLAG_W  ALU flag register.
- owner  out  1  requester granted last (or lock owner).

Behaviour:
- Reset (async, rst_n=0): all rX_rsp_valid=0, rX_rsp_out=0, rX_rsp_flags=0.
- Reset also clears the held ALU drive registers to 0 (alu_fun_sel=0, alu_a=0, alu_b=0), sets owner=INIT_PRIO, and puts the FSM in ARB. rX_ready=0 while rst_n=0.
- Eligible(X) = rX_valid & ~rX_rsp_valid, evaluated on registered slot state. A slot drained in the same cycle does not make X eligible until the next cycle.
- Grant, state ARB:
  - Only one requester eligible: grant it.
  - Both eligible: grant the requester != owner.
  - First tie after reset goes to INIT_PRIO.
- rX_ready = grant to X. Accept = rX_valid & rX_ready.
- ALU drive is combinational from the granted requester's fun_sel/a/b in the accept cycle.
- On the accept edge the issued {fun_sel,a,b} are registered. In non-accept cycles the ALU is driven from these held registers, so ALU inputs never glitch and the ALU carry state is not disturbed.
- Latency: at the accept edge, rX_rsp_out<=alu_out, rX_rsp_flags<=alu_flags, rX_rsp_valid<=1, owner<=X. Response is visible the cycle after accept.
- Response: slot holds value stable until rX_rsp_valid & rX_rsp_ready; it clears at that edge.
- Throughput: max 1 op/cycle aggregate, 1 op per 2 cycles per requester.
- No request is dropped. An un-granted valid waits.
- Fairness: with both continuously eligible, grants alternate strictly.
- States: ARB, OWN0, OWN1. Without ALU_ARB_LOCK_EN the FSM stays in ARB.
- Reset mid-operation: pending responses are discarded and lock is released.

Optional Feature:
- Macro ALU_ARB_LOCK_EN. Supports carry-chained sequences such as multi-byte add and CSR.
- With the macro:
  - Accept by X with rX_lock=1 moves ARB->OWNX (or stays in OWNX).
  - In OWNX only X can be granted; the other requester waits regardless of priority.
  - Accept by X with rX_lock=0 returns to ARB.
  - Lock does not time out.
- Without the macro: rX_lock ports exist but are ignored; FSM is always ARB.

Test Plan:
- Single op: r0 valid, fun_sel=0100, a=0x05, b=0x03, model ALU add with C=0 -> r0_ready=1 same cycle; next cycle r0_rsp_valid=1, rsp_out=0x08, flags Z=0 C=0 N=0 O=0.
- Tie after reset with INIT_PRIO=0: both valid (r0 a=0x0F b=0xF0 op 0111, r1 a=0x80 op 0000), both drain immediately -> r0 granted first (rsp_out 0x00, Z=1), r1 next cycle (rsp_out 0x80, N=1); continuous valid gives grants alternating 0,1,0,1.
- Backpressure: r1_rsp_ready=0 after first op, r1 keeps valid -> r1_ready stays 0 and r1_rsp_out is held stable; r0 receives every grant; r1 is re-granted the cycle after rsp_ready=1.
- Idle hold: after an op with a=0x55 b=0xAA fun_sel=1010, no valid for 5 cycles -> alu_a/alu_b/alu_fun_sel stay 0x55/0xAA/1010.
- Reset mid-op: assert rst_n=0 while r0_rsp_valid=1 -> rsp_valid=0 and rsp_out=0 immediately (async); ready=0 during reset.
- Lock (with ALU_ARB_LOCK_EN): r0 issues two ops with lock=1 then lock=0 while r1 is valid -> r1_ready=0 for all three r0 ops; r1 is granted on the next cycle. Without the macro the same stimulus alternates grants.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU between two requesters with per-requester response slots.
// Optional ALU ownership lock for carry-chained sequences: define ALU_ARB_LOCK_EN.
module alu_arbiter #(
   parameter int DATA_W    = 8,
   parameter int FUNSEL_W  = 4,
   parameter int FLAG_W    = 4,
   parameter int INIT_PRIO = 0
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                r0_valid,
   output logic                r0_ready,
   input  logic [FUNSEL_W-1:0] r0_fun_sel,
   input  logic [DATA_W-1:0]   r0_a,
   input  logic [DATA_W-1:0]   r0_b,
   input  logic                r0_lock,
   output logic                r0_rsp_valid,
   input  logic                r0_rsp_ready,
   output logic [DATA_W-1:0]   r0_rsp_out,
   output logic [FLAG_W-1:0]   r0_rsp_flags,
   input  logic                r1_valid,
   output logic                r1_ready,
   input  logic [FUNSEL_W-1:0] r1_fun_sel,
   input  logic [DATA_W-1:0]   r1_a,
   input  logic [DATA_W-1:0]   r1_b,
   input  logic                r1_lock,
   output logic                r1_rsp_valid,
   input  logic                r1_rsp_ready,
   output logic [DATA_W-1:0]   r1_rsp_out,
   output logic [FLAG_W-1:0]   r1_rsp_flags,
   output logic [FUNSEL_W-1:0] alu_fun_sel,
   output logic [DATA_W-1:0]   alu_a,
   output logic [DATA_W-1:0]   alu_b,
   input  logic [DATA_W-1:0]   alu_out,
   input  logic [FLAG_W-1:0]   alu_flags,
   output logic                owner
);
   typedef enum logic [1:0] {ARB, OWN0, OWN1} state_t;
   localparam logic P_INIT = INIT_PRIO[0];
   state_t              r_state, w_next;
   logic                r_owner, r_first;
   logic [FUNSEL_W-1:0] r_fun;
   logic [DATA_W-1:0]   r_a, r_b;
   logic                r_vld0, r_vld1;
   logic [DATA_W-1:0]   r_out0, r_out1;
   logic [FLAG_W-1:0]   r_flg0, r_flg1;
   logic                w_el0, w_el1, w_pick1, w_g0, w_g1;

   assign w_el0   = r0_valid & ~r_vld0;
   assign w_el1   = r1_valid & ~r_vld1;
   // tie winner: INIT_PRIO until the first grant, then whoever was not granted last
   assign w_pick1 = r_first ? P_INIT : ~r_owner;
   assign w_g0    = rst_n & w_el0 & ((r_state == OWN0) | ((r_state == ARB) & (~w_el1 | ~w_pick1)));
   assign w_g1    = rst_n & w_el1 & ((r_state == OWN1) | ((r_state == ARB) & (~w_el0 | w_pick1)));

   assign r0_ready     = w_g0;
   assign r1_ready     = w_g1;
   assign alu_fun_sel  = w_g0 ? r0_fun_sel : w_g1 ? r1_fun_sel : r_fun;
   assign alu_a        = w_g0 ? r0_a : w_g1 ? r1_a : r_a;
   assign alu_b        = w_g0 ? r0_b : w_g1 ? r1_b : r_b;
   assign owner        = r_owner;
   assign r0_rsp_valid = r_vld0;
   assign r1_rsp_valid = r_vld1;
   assign r0_rsp_out   = r_out0;
   assign r1_rsp_out   = r_out1;
   assign r0_rsp_flags = r_flg0;
   assign r1_rsp_flags = r_flg1;

`ifdef ALU_ARB_LOCK_EN
   always_comb begin
      w_next = r_state;
      if (w_g0) w_next = r0_lock ? OWN0 : ARB;
      else if (w_g1) w_next = r1_lock ? OWN1 : ARB;
   end
`else
   logic w_unused_lock;
   assign w_unused_lock = ^{r0_lock, r1_lock};
   always_comb begin
      w_next = ARB;
   end
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ARB;
         r_owner <= P_INIT;
         r_first <= 1'b1;
         r_fun   <= '0;
         r_a     <= '0;
         r_b     <= '0;
         r_vld0  <= 1'b0;
         r_vld1  <= 1'b0;
         r_out0  <= '0;
         r_out1  <= '0;
         r_flg0  <= '0;
         r_flg1  <= '0;
      end else begin
         r_state <= w_next;
         if (w_g0 | w_g1) begin
            r_fun   <= alu_fun_sel;
            r_a     <= alu_a;
            r_b     <= alu_b;
            r_owner <= w_g1;
            r_first <= 1'b0;
         end
         if (w_g0) begin
            r_vld0 <= 1'b1;
            r_out0 <= alu_out;
            r_flg0 <= alu_flags;
         end else if (r0_rsp_ready) r_vld0 <= 1'b0;
         if (w_g1) begin
            r_vld1 <= 1'b1;
            r_out1 <= alu_out;
            r_flg1 <= alu_flags;
         end else if (r1_rsp_ready) r_vld1 <= 1'b0;
      end
   end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter with a small combinational ALU model.
module tb_alu_arbiter;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       r0_valid, r0_ready, r0_lock, r0_rsp_valid, r0_rsp_ready;
   logic       r1_valid, r1_ready, r1_lock, r1_rsp_valid, r1_rsp_ready;
   logic [3:0] r0_fun_sel, r1_fun_sel, r0_rsp_flags, r1_rsp_flags;
   logic [7:0] r0_a, r0_b, r1_a, r1_b, r0_rsp_out, r1_rsp_out;
   logic [3:0] alu_fun_sel, alu_flags;
   logic [7:0] alu_a, alu_b, alu_out;
   logic       owner;
   logic [8:0] t;
   int         n_chk = 0, n_fail = 0;

   always #5 clk = ~clk;

   alu_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_fun_sel(r0_fun_sel), .r0_a(r0_a), .r0_b(r0_b),
      .r0_lock(r0_lock), .r0_rsp_valid(r0_rsp_valid), .r0_rsp_ready(r0_rsp_ready),
      .r0_rsp_out(r0_rsp_out), .r0_rsp_flags(r0_rsp_flags),
      .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_fun_sel(r1_fun_sel), .r1_a(r1_a), .r1_b(r1_b),
      .r1_lock(r1_lock), .r1_rsp_valid(r1_rsp_valid), .r1_rsp_ready(r1_rsp_ready),
      .r1_rsp_out(r1_rsp_out), .r1_rsp_flags(r1_rsp_flags),
      .alu_fun_sel(alu_fun_sel), .alu_a(alu_a), .alu_b(alu_b),
      .alu_out(alu_out), .alu_flags(alu_flags), .owner(owner)
   );

   // ALU model: 0000 pass a, 0100 add, 0111 and, 1010 xor, else or; flags {Z,C,N,O}
   always_comb begin
      t = {1'b0, alu_a | alu_b};
      if (alu_fun_sel == 4'b0000) t = {1'b0, alu_a};
      else if (alu_fun_sel == 4'b0100) t = {1'b0, alu_a} + {1'b0, alu_b};
      else if (alu_fun_sel == 4'b0111) t = {1'b0, alu_a & alu_b};
      else if (alu_fun_sel == 4'b1010) t = {1'b0, alu_a ^ alu_b};
      alu_out   = t[7:0];
      alu_flags = {t[7:0] == 8'd0, t[8], t[7],
                   (alu_fun_sel == 4'b0100) & (alu_a[7] == alu_b[7]) & (t[7] != alu_a[7])};
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      r0_valid = 1'b0;
      r1_valid = 1'b0;
      step();
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
      step();
   endtask

   initial begin
      rst_n = 1'b0;
      {r0_lock, r1_lock, r0_rsp_ready, r1_rsp_ready, r1_valid} = '0;
      {r0_fun_sel, r0_a, r0_b, r1_fun_sel, r1_a, r1_b} = '0;
      r0_valid = 1'b1;
      #2;
      chk("rst_ready", r0_ready, 0);
      chk("rst_rsp_valid", {r0_rsp_valid, r1_rsp_valid}, 0);
      chk("rst_rsp_out", {r0_rsp_out, r1_rsp_out}, 0);
      chk("rst_rsp_flags", {r0_rsp_flags, r1_rsp_flags}, 0);
      chk("rst_alu", {alu_fun_sel, alu_a, alu_b}, 0);
      chk("rst_owner", owner, 0);
      r0_valid = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      // single op: 5 + 3
      r0_valid = 1'b1; r0_fun_sel = 4'b0100; r0_a = 8'h05; r0_b = 8'h03;
      #1;
      chk("single_ready", r0_ready, 1);
      chk("single_alu_a", alu_a, 8'h05);
      step();
      r0_valid = 1'b0;
      #1;
      chk("single_rsp_valid", r0_rsp_valid, 1);
      chk("single_rsp_out", r0_rsp_out, 8'h08);
      chk("single_rsp_flags", r0_rsp_flags, 4'b0000);
      chk("single_owner", owner, 0);
      r0_rsp_ready = 1'b1;
      step();
      chk("single_drain", r0_rsp_valid, 0);
      // tie after reset, then strict alternation
      do_reset();
      r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
      r0_valid = 1'b1; r0_fun_sel = 4'b0111; r0_a = 8'h0F; r0_b = 8'hF0;
      r1_valid = 1'b1; r1_fun_sel = 4'b0000; r1_a = 8'h80; r1_b = 8'h00;
      for (int i = 0; i < 6; i++) begin
         #1;
         chk("tie_r0_ready", r0_ready, !i[0]);
         chk("tie_r1_ready", r1_ready, i[0]);
         if (i == 1) chk("tie_r0_rsp", {r0_rsp_out, r0_rsp_flags}, {8'h00, 4'b1000});
         if (i == 2) chk("tie_r1_rsp", {r1_rsp_out, r1_rsp_flags}, {8'h80, 4'b0010});
         step();
      end
      // backpressure on r1
      do_reset();
      r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b0;
      r0_valid = 1'b1; r0_fun_sel = 4'b0100; r0_a = 8'h01; r0_b = 8'h01;
      r1_valid = 1'b1; r1_fun_sel = 4'b0000; r1_a = 8'h42; r1_b = 8'h00;
      for (int i = 0; i < 10; i++) begin
         r1_rsp_ready = (i == 8);
         #1;
         chk("bp_r0_ready", r0_ready, !i[0]);
         chk("bp_r1_ready", r1_ready, (i == 1) || (i == 9));
         if (i >= 2 && i <= 8) chk("bp_r1_hold", {r1_rsp_valid, r1_rsp_out}, {1'b1, 8'h42});
         step();
      end
      r0_valid = 1'b0; r1_valid = 1'b0; r1_rsp_ready = 1'b1;
      step();
      step();
      // idle hold of ALU drive
      r0_valid = 1'b1; r0_fun_sel = 4'b1010; r0_a = 8'h55; r0_b = 8'hAA;
      #1;
      chk("idle_ready", r0_ready, 1);
      step();
      r0_valid = 1'b0;
      #1;
      chk("idle_rsp", {r0_rsp_out, r0_rsp_flags}, {8'hFF, 4'b0010});
      for (int i = 0; i < 5; i++) begin
         chk("idle_alu", {alu_fun_sel, alu_a, alu_b}, {4'b1010, 8'h55, 8'hAA});
         step();
      end
      // asynchronous reset while a response is pending
      r0_rsp_ready = 1'b0;
      r0_valid = 1'b1; r0_fun_sel = 4'b0100; r0_a = 8'h01; r0_b = 8'h01;
      step();
      #1;
      chk("midrst_pre", {r0_rsp_valid, r0_rsp_out}, {1'b1, 8'h02});
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", r0_rsp_valid, 0);
      chk("midrst_out", r0_rsp_out, 0);
      chk("midrst_ready", r0_ready, 0);
      chk("midrst_alu", {alu_fun_sel, alu_a, alu_b}, 0);
      r0_valid = 1'b0;
      step();
      rst_n = 1'b1;
      step();
      // lock sequence: r0 issues lock=1, lock=1, lock=0 with r1 waiting
      r0_rsp_ready = 1'b1; r1_rsp_ready = 1'b1;
      r0_fun_sel = 4'b0100; r0_a = 8'h03; r0_b = 8'h04;
      r1_valid = 1'b1; r1_fun_sel = 4'b0000; r1_a = 8'h09; r1_b = 8'h00;
      for (int c = 0; c < 6; c++) begin
         r0_valid = (c < 5);
         r0_lock  = (c < 4);
         #1;
`ifdef ALU_ARB_LOCK_EN
         chk("lock_r0_ready", r0_ready, (c == 0) || (c == 2) || (c == 4));
         chk("lock_r1_ready", r1_ready, c == 5);
`else
         chk("lock_r0_ready", r0_ready, (c < 5) && !c[0]);
         chk("lock_r1_ready", r1_ready, c[0]);
`endif
         step();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
